// File: rtl/wdata_bus_pkg.sv
// Shared encodings for the WDATA bus arbiter and the downstream WDATA mux.
package wdata_bus_pkg;

    // FSM state encoding, kept as plain constants so older tools and
    // debug scripts can match on the raw two-bit value.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'b00;
    localparam state_t ST_GNT0 = 2'b01;
    localparam state_t ST_GNT1 = 2'b10;
    localparam state_t ST_TURN = 2'b11;

    // Mux select encodings, shared with the WDATA 2:1 mux instance.
    localparam logic MASTER_0 = 1'b0;
    localparam logic MASTER_1 = 1'b1;

endpackage

// File: rtl/wdata_bus_arbiter_hold_counter.sv
// Saturating hold-time counter. The terminal flag stays high once the count
// reaches MAX_HOLD-1, so late contention still preempts at the next edge.
module hold_counter #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic term_o
);
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] TERM_C = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and stop at MAX_HOLD.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && (cnt_q != MAX_C))
            cnt_d = cnt_q + 1'b1;
    end

    // Count register, synchronously cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign term_o = (cnt_q >= TERM_C);

endmodule

// File: rtl/wdata_bus_arbiter.sv
// Two-master round-robin WDATA arbiter with bounded hold time and a single
// dead turnaround cycle between owners. All outputs come from registers.
module wdata_bus_arbiter
    import wdata_bus_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic req_0,
    input  logic req_1,
    output logic grant_0,
    output logic grant_1,
    output logic sel,
    output logic bus_busy,
    output logic preempt
);
    state_t state_q, state_d;
    logic   last_q, last_d;
    logic   sel_q, sel_d;
    logic   gnt0_q, gnt0_d;
    logic   gnt1_q, gnt1_d;
    logic   pre_q, pre_d;
    logic   hold_term;
    logic   in_grant;

    assign in_grant = (state_q == ST_GNT0) || (state_q == ST_GNT1);

    // Counter is held at zero outside a grant, so it reads 0 in the first
    // grant cycle and counts once per granted cycle after that.
    hold_counter #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (CNT_W)
    ) u_hold (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (!in_grant),
        .en_i   (in_grant),
        .term_o (hold_term)
    );

    // Next state: IDLE and TURN share the arbitration decision; a grant ends
    // on release or on hold expiry with the other master waiting.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        pre_d   = 1'b0;
        case (state_q)
            ST_GNT0: begin
                if (!req_0) begin
                    state_d = ST_TURN;
                end else if (hold_term && req_1) begin
                    state_d = ST_TURN;
                    pre_d   = 1'b1;
                end
            end
            ST_GNT1: begin
                if (!req_1) begin
                    state_d = ST_TURN;
                end else if (hold_term && req_0) begin
                    state_d = ST_TURN;
                    pre_d   = 1'b1;
                end
            end
            default: begin
                // Tie goes to whichever master was not served last.
                if (req_0 && (!req_1 || (last_q == MASTER_1))) begin
                    state_d = ST_GNT0;
                    sel_d   = MASTER_0;
                    last_d  = MASTER_0;
                end else if (req_1) begin
                    state_d = ST_GNT1;
                    sel_d   = MASTER_1;
                    last_d  = MASTER_1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
        gnt0_d = (state_d == ST_GNT0);
        gnt1_d = (state_d == ST_GNT1);
    end

    // State and output registers; reset drops any grant immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            last_q  <= MASTER_1;
            sel_q   <= MASTER_0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            pre_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            pre_q   <= pre_d;
        end
    end

    assign grant_0  = gnt0_q;
    assign grant_1  = gnt1_q;
    assign sel      = sel_q;
    assign preempt  = pre_q;
    assign bus_busy = gnt0_q | gnt1_q;

endmodule

// File: tb/tb_wdata_bus_arbiter.sv
// Directed bench for wdata_bus_arbiter (MAX_HOLD = 16).
// Observed vector is {grant_0, grant_1, sel, preempt, bus_busy}.
module tb_wdata_bus_arbiter;
    logic clk, reset, req_0, req_1;
    logic grant_0, grant_1, sel, bus_busy, preempt;
    int   checks = 0;
    int   errors = 0;

    localparam logic [4:0] V_IDLE0 = 5'b00000; // idle/turn, sel 0
    localparam logic [4:0] V_IDLE1 = 5'b00100; // idle/turn, sel 1
    localparam logic [4:0] V_G0    = 5'b10001;
    localparam logic [4:0] V_G1    = 5'b01101;
    localparam logic [4:0] V_PRE0  = 5'b00010; // preempt turn, sel 0
    localparam logic [4:0] V_PRE1  = 5'b00110; // preempt turn, sel 1

    wdata_bus_arbiter #(.MAX_HOLD(16), .CNT_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_0    (req_0),
        .req_1    (req_1),
        .grant_0  (grant_0),
        .grant_1  (grant_1),
        .sel      (sel),
        .bus_busy (bus_busy),
        .preempt  (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {grant_0, grant_1, sel, preempt, bus_busy};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; req_0 = 1'b0; req_1 = 1'b0;
        #1;
        step(); step();
        check("reset", V_IDLE0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin step(); check("idle", V_IDLE0); end

        // Single master 1 for 5 cycles, then release.
        req_1 = 1'b1;
        for (int i = 0; i < 5; i++) begin step(); check("single_g1", V_G1); end
        req_1 = 1'b0;
        step(); check("single_release", V_IDLE1);
        step(); check("single_idle_sel", V_IDLE1);

        // Simultaneous first request after reset: master 0 first.
        reset = 1'b1; step(); check("reset2", V_IDLE0); reset = 1'b0;
        req_0 = 1'b1; req_1 = 1'b1;
        for (int i = 0; i < 3; i++) begin step(); check("tie_g0", V_G0); end
        req_0 = 1'b0;
        step(); check("tie_turn", V_IDLE0);
        step(); check("tie_g1", V_G1);
        req_1 = 1'b0;
        step(); check("tie_g1_release", V_IDLE1);
        step(); check("tie_idle", V_IDLE1);

        // Preemption: master 1 arrives during master 0's first grant cycle.
        req_0 = 1'b1;
        step(); check("pre_g0_c1", V_G0);
        req_1 = 1'b1;
        for (int i = 2; i <= 16; i++) begin step(); check("pre_g0_hold", V_G0); end
        step(); check("pre_turn0", V_PRE0);
        for (int i = 1; i <= 16; i++) begin step(); check("pre_g1_hold", V_G1); end
        step(); check("pre_turn1", V_PRE1);
        step(); check("pre_g0_again", V_G0);
        req_0 = 1'b0; req_1 = 1'b0;
        step(); check("pre_release", V_IDLE0);
        step(); check("pre_idle", V_IDLE0);

        // No contention: grant persists past MAX_HOLD; late req_1 preempts.
        req_0 = 1'b1;
        for (int i = 1; i <= 30; i++) begin step(); check("nocont_g0", V_G0); end
        req_1 = 1'b1;
        step(); check("late_preempt", V_PRE0);
        for (int i = 1; i <= 16; i++) begin step(); check("late_g1", V_G1); end
        // Release coincides with expiry: release wins, no preempt pulse.
        req_1 = 1'b0;
        step(); check("release_at_expiry", V_IDLE1);
        req_0 = 1'b0; req_1 = 1'b1;
        step(); check("regrant_g1", V_G1);

        // Reset mid-grant drops grant and sel at that edge.
        reset = 1'b1; req_0 = 1'b1;
        step(); check("reset_mid_grant", V_IDLE0);
        reset = 1'b0;
        step(); check("post_reset_g0", V_G0);
        req_0 = 1'b0; req_1 = 1'b0;
        step(); check("final_turn", V_IDLE0);
        step(); check("final_idle", V_IDLE0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
